// File: rtl/opb_status_snapshot_ctrl.sv
// opb_status_snapshot_ctrl
//   OPB slave that captures N_SRC 32-bit status words on a single clock edge
//   so software can read a coherent multi-word snapshot.
//   A capture is started by a CTRL write (bit0) or by a rising edge on ext_trig
//   when ext_en is set. An optional settle delay runs before the capture.
//
// Ports
//   OPB_Clk, OPB_Rst          clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW      OPB request (big-endian bit numbering)
//   OPB_select, OPB_seqAddr   transfer request, sequential hint (unused)
//   Sl_DBus, Sl_xferAck       read data (valid only while acked), acknowledge
//   Sl_errAck/retry/toutSup   tied low
//   status_in                 word i at status_in[32i+31:32i]
//   ext_trig                  hardware trigger, synchronous to OPB_Clk
//   snap_busy, snap_done      sequence in progress, snapshot valid
module opb_status_snapshot_ctrl #(
  parameter logic [31:0] C_BASEADDR    = 32'h01080C00,
  parameter logic [31:0] C_HIGHADDR    = 32'h01080CFF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          N_SRC         = 4,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [32*N_SRC-1:0]     status_in,
  input  logic                    ext_trig,
  output logic                    snap_busy,
  output logic                    snap_done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_done;
  logic        r_ext_en;
  logic [7:0]  r_snap_cnt;
  logic [7:0]  r_ovr;
  logic [31:0] r_snap [N_SRC];

  logic        r_ack;
  logic [5:0]  r_off;
  logic        r_rnw;
  logic        r_be3;
  logic [2:0]  r_wbits;

  logic        r_ext_p0;
  logic        r_ext_pulse_p1;

  logic        w_hit;
  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_trig;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_busy    = (r_state != S_IDLE);
  // Writes commit in the acknowledge cycle using the request latched at hit.
  assign w_ctrl_wr = r_ack && !r_rnw && (r_off == 6'd0) && r_be3;
  assign w_clear   = w_ctrl_wr && r_wbits[1];
  // Software and hardware triggers merge into one; coincident sources count once.
  assign w_trig    = (w_ctrl_wr && r_wbits[0]) || r_ext_pulse_p1;
  assign w_unused  = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-4]};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_done         <= 1'b0;
      r_ext_en       <= 1'b0;
      r_snap_cnt     <= 8'd0;
      r_ovr          <= 8'd0;
      r_ack          <= 1'b0;
      r_ext_p0       <= 1'b0;
      r_ext_pulse_p1 <= 1'b0;
      for (int i = 0; i < N_SRC; i++) r_snap[i] <= 32'd0;
    end else begin
      // Bus stage: ack one cycle after hit, never on two consecutive cycles.
      r_ack <= w_hit && !r_ack;
      if (w_hit && !r_ack) begin
        r_off   <= OPB_ABus[24:29];
        r_rnw   <= OPB_RNW;
        r_be3   <= OPB_BE[3];
        r_wbits <= OPB_DBus[C_OPB_DWIDTH-3:C_OPB_DWIDTH-1];
      end

      // Edge-detect stage: rising edge in cycle E becomes a trigger in E+1.
      r_ext_p0       <= ext_trig;
      r_ext_pulse_p1 <= r_ext_en && ext_trig && !r_ext_p0;

      if (w_ctrl_wr) r_ext_en <= r_wbits[2];

      // Clear wins over a coincident overrun.
      if (w_clear)                                r_ovr <= 8'd0;
      else if (w_trig && w_busy && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;

      // A capture wins over a coincident clear.
      if (r_state == S_CAPTURE) r_done <= 1'b1;
      else if (w_clear)         r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            if (SETTLE_CYCLES == 0) begin
              r_state <= S_CAPTURE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 8'(SETTLE_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= 8'd1) r_state <= S_CAPTURE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_CAPTURE: begin
          for (int i = 0; i < N_SRC; i++) r_snap[i] <= status_in[32*i +: 32];
          r_snap_cnt <= r_snap_cnt + 8'd1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read mux sees the registers as they stand in the ack cycle, so a read
  // acked in the capture cycle still returns the previous snapshot.
  always_comb begin
    w_rdata = 32'd0;
    if (r_off == 6'd0) w_rdata = {8'd0, r_ovr, r_snap_cnt, 5'd0, r_ext_en, w_busy, r_done};
    for (int i = 0; i < N_SRC; i++) begin
      if (r_off == 6'(4 + i)) w_rdata = r_snap[i];
    end
  end

  assign Sl_DBus    = (r_ack && r_rnw) ? w_rdata : '0;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign snap_busy  = w_busy;
  assign snap_done  = r_done;

endmodule

// File: tb/tb_opb_status_snapshot_ctrl.sv
// Bench for opb_status_snapshot_ctrl: randomized stimulus checked against a
// cycle-indexed reference model of triggers, captures, clears and overruns.
module tb_opb_status_snapshot_ctrl;

  localparam int          N    = 4;
  localparam int          S    = 2;
  localparam int          HN   = 4096;
  localparam logic [31:0] BASE = 32'h01080C00;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus;
  logic          rnw, sel, seqa;
  logic [0:31]   sdbus;
  logic          ack, erra, retry, tout;
  logic [127:0]  status_in;
  logic          ext_trig;
  logic          busy, done;

  always #5 clk = ~clk;

  opb_status_snapshot_ctrl #(
    .C_BASEADDR(32'h01080C00), .C_HIGHADDR(32'h01080CFF),
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .N_SRC(N), .SETTLE_CYCLES(S)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
    .Sl_DBus(sdbus), .Sl_xferAck(ack), .Sl_errAck(erra), .Sl_retry(retry),
    .Sl_toutSup(tout), .status_in(status_in), .ext_trig(ext_trig),
    .snap_busy(busy), .snap_done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] hist [HN];
  bit ramp_en = 1'b0;
  bit const_bad = 1'b0;

  // Cycle counter plus a record of status_in as it stood during each cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (ramp_en) status_in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    hist[cyc % HN] = status_in;
  end

  always @(negedge clk) if (erra || retry || tout) const_bad = 1'b1;

  // Reference model: everything is expressed in cycle numbers.
  int m_start, m_cap, m_prev_cap, m_clear, m_cnt, m_ovr;
  bit m_ext_en;

  function automatic void model_reset();
    m_start = -10; m_cap = -10; m_prev_cap = -10; m_clear = -1;
    m_cnt = 0; m_ovr = 0; m_ext_en = 1'b0;
  endfunction

  function automatic void model_clear(int t);
    m_clear = t;
    m_ovr   = 0;
  endfunction

  function automatic void model_trigger(int t);
    if (t == m_start) return;
    if (t > m_start && t <= m_cap) begin
      if (m_clear != t && m_ovr < 255) m_ovr++;
    end else begin
      m_prev_cap = m_cap;
      m_start    = t;
      m_cap      = t + 1 + S;
      m_cnt++;
    end
  endfunction

  function automatic int last_cap(int now);
    return (m_cap < now) ? m_cap : m_prev_cap;
  endfunction

  function automatic logic [31:0] exp_ctrl(int now);
    logic [7:0] c, o;
    logic b, d;
    c = 8'(m_cnt - ((m_cap >= now) ? 1 : 0));
    o = 8'(m_ovr);
    b = (now > m_start) && (now <= m_cap);
    d = (last_cap(now) >= 0) && (last_cap(now) >= m_clear);
    return {8'd0, o, c, 5'd0, m_ext_en, b, d};
  endfunction

  function automatic logic [31:0] exp_snap(int i, int now);
    int ce;
    logic [127:0] h;
    ce = last_cap(now);
    if (ce < 0) return 32'd0;
    h = hist[ce % HN];
    return h[32*i +: 32];
  endfunction

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One OPB transfer; caller is 1 time unit after a rising edge.
  task automatic bus_xfer(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                          input logic [3:0] b, input bit with_ext,
                          output logic [31:0] rdata, output int tack);
    int n;
    sel = 1'b1; abus = addr; rnw = rd; dbus = wd; be = b;
    if (with_ext) ext_trig = 1'b1;
    n = 0;
    @(negedge clk);
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout addr=%h: ack=%b expected 1", addr, ack);
    end
    rdata = sdbus;
    tack  = cyc;
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0; abus = '0;
    if (with_ext) ext_trig = 1'b0;
  endtask

  task automatic sw_write(input logic [2:0] d, input logic [3:0] b, input bit with_ext);
    logic [31:0] rd;
    int t;
    bit ext_fire;
    ext_fire = with_ext && m_ext_en;
    bus_xfer(BASE, 1'b0, {29'd0, d}, b, with_ext, rd, t);
    if (b[3] && d[1]) model_clear(t);
    if ((b[3] && d[0]) || ext_fire) model_trigger(t);
    if (b[3]) m_ext_en = d[2];
  endtask

  task automatic check_ctrl(input string nm);
    logic [31:0] d, e;
    int t;
    bus_xfer(BASE, 1'b1, 32'd0, 4'hF, 1'b0, d, t);
    e = exp_ctrl(t);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: CTRL got %h expected %h", nm, d, e);
    end
  endtask

  task automatic check_snap(input string nm, input int i);
    logic [31:0] d, e;
    int t;
    bus_xfer(BASE + 32'h10 + 32'(4*i), 1'b1, 32'd0, 4'hF, 1'b0, d, t);
    e = exp_snap(i, t);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: SNAP%0d got %h expected %h", nm, i, d, e);
    end
  endtask

  task automatic ext_pulse(input int len);
    int e;
    ext_trig = 1'b1;
    e = cyc;
    if (m_ext_en) model_trigger(e + 1);
    cyc_wait(len);
    ext_trig = 1'b0;
    cyc_wait(1);
  endtask

  task automatic set_random_status();
    status_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc_wait(1);
    @(negedge clk);
    checks++;
    if ({ack, sdbus, busy, done} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b dbus=%h busy=%b done=%b expected all 0",
               ack, sdbus, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_ctrl("reset_ctrl");
    check_snap("reset_snap", 0);
  endtask

  task automatic test_sw_capture();
    logic eb, ed;
    for (int i = 0; i < N; i++) status_in[32*i +: 32] = 32'hA5A50000 + 32'(i);
    sw_write(3'b001, 4'hF, 1'b0);
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      eb = (k <= S + 1);
      ed = (k >= S + 2);
      checks++;
      if (busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL sw_timing T+%0d: busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, eb, ed);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) check_snap("sw_snap", i);
    check_ctrl("sw_ctrl");
  endtask

  task automatic test_coherence();
    ramp_en = 1'b1;
    sw_write(3'b001, 4'hF, 1'b0);
    cyc_wait(S + 2 + $urandom_range(0, 5));
    for (int i = 0; i < N; i++) check_snap("coherence_snap", i);
    ramp_en = 1'b0;
    check_ctrl("coherence_ctrl");
  endtask

  task automatic test_overrun_clear();
    set_random_status();
    sw_write(3'b001, 4'hF, 1'b0);
    sw_write(3'b001, 4'hF, 1'b0);
    cyc_wait(S + 2);
    check_ctrl("overrun_ctrl");
    check_snap("overrun_snap", 1);
    sw_write(3'b010, 4'hF, 1'b0);
    check_ctrl("clear_ctrl");
  endtask

  task automatic test_ext_trigger();
    set_random_status();
    sw_write(3'b100, 4'hF, 1'b0);
    ext_pulse(3);
    cyc_wait(S + 2);
    check_ctrl("ext_ctrl");
    check_snap("ext_snap", N - 1);
    set_random_status();
    sw_write(3'b000, 4'hF, 1'b0);
    ext_pulse(3);
    cyc_wait(S + 2);
    check_ctrl("ext_disabled_ctrl");
    check_snap("ext_disabled_snap", 0);
    sw_write(3'b100, 4'hF, 1'b0);
    sw_write(3'b101, 4'hF, 1'b1);
    cyc_wait(S + 2);
    check_ctrl("ext_coincident_ctrl");
  endtask

  task automatic test_bus_protocol();
    logic [31:0] rd;
    int t;
    logic ea;
    sel = 1'b1; abus = BASE + 32'hFC; rnw = 1'b1; be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = (k % 2 == 1);
      checks++;
      if (ack !== ea) begin
        errors++;
        $display("FAIL ack_pattern cycle %0d: ack=%b expected %b", k, ack, ea);
      end
      if (ea) begin
        checks++;
        if (sdbus !== 32'd0) begin
          errors++;
          $display("FAIL unmapped_read: got %h expected 00000000", sdbus);
        end
      end
      @(posedge clk); #1;
    end
    sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
    bus_xfer(BASE, 1'b0, 32'h7, 4'b1110, 1'b0, rd, t);
    cyc_wait(S + 2);
    check_ctrl("be_gated_ctrl");
    bus_xfer(BASE + 32'h10, 1'b0, $urandom, 4'hF, 1'b0, rd, t);
    check_snap("snap_write_ignored", 0);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int t;
    sw_write(3'b100, 4'hF, 1'b0);
    for (int it = 0; it < 30; it++) begin
      if (!ramp_en) set_random_status();
      ramp_en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: sw_write(3'b101, 4'hF, 1'b0);
        1: sw_write(3'b111, 4'hF, 1'b0);
        2: sw_write(3'b110, 4'hF, 1'b0);
        3: ext_pulse($urandom_range(1, 3));
        4: bus_xfer(BASE + 32'h10 + 32'(4*$urandom_range(0, N-1)), 1'b0, $urandom,
                    4'hF, 1'b0, rd, t);
        default: begin
          bus_xfer(BASE + 32'(4*$urandom_range(12, 63)), 1'b1, 32'd0, 4'hF, 1'b0, rd, t);
          checks++;
          if (rd !== 32'd0) begin
            errors++;
            $display("FAIL random_unmapped: got %h expected 00000000", rd);
          end
        end
      endcase
      cyc_wait($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) check_ctrl("random_ctrl");
      else check_snap("random_snap", $urandom_range(0, N-1));
    end
    ramp_en = 1'b0;
    cyc_wait(S + 3);
    check_ctrl("random_final_ctrl");
  endtask

  task automatic test_reset_abort();
    set_random_status();
    sw_write(3'b001, 4'hF, 1'b0);
    rst = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    model_reset();
    cyc_wait(S + 2);
    check_ctrl("abort_ctrl");
    check_snap("abort_snap", 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; seqa = 1'b0;
    ext_trig = 1'b0; status_in = '0;
    model_reset();
    test_reset();
    test_sw_capture();
    test_coherence();
    test_overrun_clear();
    test_ext_trigger();
    test_bus_protocol();
    test_random();
    test_reset_abort();
    checks++;
    if (const_bad) begin
      errors++;
      $display("FAIL const_outputs: errAck/retry/toutSup seen 1, expected always 0");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
